// File: rtl/tx_byte_queue_if.sv
// Byte-valid link between a producer, the transmit queue and the UART transmitter.
// The slave modport is the queue itself; the master modport is everything around it.
interface tx_byte_queue_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [7:0]      i_byte;
    logic            i_byte_v;
    logic [7:0]      o_byte;
    logic            o_byte_v;
    logic            i_tx_active;
    logic            i_tx_done;
    logic [ADDR_W:0] o_count;
    logic            o_full;
    logic            o_empty;
    logic            o_overflow;
    logic            o_lost;

    modport slave (
        input  i_byte, i_byte_v, i_tx_active, i_tx_done,
        output o_byte, o_byte_v, o_count, o_full, o_empty, o_overflow, o_lost
    );

    modport master (
        output i_byte, i_byte_v, i_tx_active, i_tx_done,
        input  o_byte, o_byte_v, o_count, o_full, o_empty, o_overflow, o_lost
    );
endinterface

// File: rtl/tx_byte_queue.sv
// Transmit byte queue: buffers single-cycle byte pushes and replays them one at a time
// into a UART transmitter using its DV / active / done handshake.
module tx_byte_queue #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned ACT_TIMEOUT = 15
) (
    input logic           clk,
    input logic           rst,
    tx_byte_queue_if.slave q
);
    localparam int unsigned Depth  = 2 ** ADDR_W;
    localparam int unsigned TimerW = (ACT_TIMEOUT > 0) ? $clog2(ACT_TIMEOUT + 1) : 1;
    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(Depth);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(ACT_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWaitAct, StWaitDone, StCooldown} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              lost_q, lost_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_v_q, byte_v_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [7:0]        mem_q [Depth];

    logic pop;
    logic push_ok;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        byte_d   = byte_q;
        byte_v_d = 1'b0;
        lost_d   = 1'b0;
        pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Never launch while the transmitter is busy or still in its done/cleanup cycles.
                if (!empty_q && !q.i_tx_active && !q.i_tx_done) begin
                    pop      = 1'b1;
                    byte_d   = mem_q[rd_ptr_q];
                    byte_v_d = 1'b1;
                    timer_d  = '0;
                    state_d  = StWaitAct;
                end
            end
            StWaitAct: begin
                if (q.i_tx_active) begin
                    state_d = StWaitDone;
                end else if (timer_q == TimerMax) begin
                    lost_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StWaitDone: begin
                // Active dropping without done still ends the frame.
                if (q.i_tx_done || !q.i_tx_active) begin
                    state_d = StCooldown;
                end
            end
            StCooldown: begin
                if (!q.i_tx_done && !q.i_tx_active) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        push_ok  = q.i_byte_v && (!full_q || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DepthCnt);
        empty_d = (count_d == '0);
        ovf_d   = ovf_q | (q.i_byte_v && !push_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
            byte_q   <= 8'h00;
            byte_v_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            lost_q   <= lost_d;
            byte_q   <= byte_d;
            byte_v_q <= byte_v_d;
            timer_q  <= timer_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= q.i_byte;
        end
    end

    assign q.o_byte     = byte_q;
    assign q.o_byte_v   = byte_v_q;
    assign q.o_count    = count_q;
    assign q.o_full     = full_q;
    assign q.o_empty    = empty_q;
    assign q.o_overflow = ovf_q;
    assign q.o_lost     = lost_q;
endmodule
